// File: rtl/oflow_iou_scheduler.sv
// oflow_iou_scheduler: walks up to MAX_HIST history bboxes through the shared IOU engine, streams
// each per-pair cost and reports the minimum cost, its index and a threshold match. Optional engine
// watchdog is enabled by defining OFLOW_IOU_SCHED_TIMEOUT_EN.
module oflow_iou_scheduler #(
    parameter int MAX_HIST    = 16,
    parameter int IDX_LEN     = 4,
    parameter int IOU_LEN     = 22,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic               clk,
    input  logic               reset_N,
    input  logic               start,
    input  logic [IDX_LEN:0]   num_history,
    input  logic [IOU_LEN-1:0] cfg_thresh,
    output logic               hist_rd_en,
    output logic [IDX_LEN-1:0] hist_rd_addr,
    output logic               eng_start,
    input  logic               eng_valid_iou,
    input  logic [IOU_LEN-1:0] eng_iou,
    output logic               score_vld,
    output logic [IDX_LEN-1:0] score_idx,
    output logic [IOU_LEN-1:0] score_data,
    output logic               busy,
    output logic               done,
    output logic [IDX_LEN-1:0] best_idx,
    output logic [IOU_LEN-1:0] best_score,
    output logic               match,
    output logic               timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LAUNCH, S_WAIT, S_UPDATE, S_DONE
    } state_t;

    localparam logic [IDX_LEN:0] MAX_N = (IDX_LEN+1)'(MAX_HIST);

    state_t               state_q, state_d;
    logic [IDX_LEN-1:0]   idx_q, idx_d, last_q, last_d, bidx_q, bidx_d;
    logic [IOU_LEN-1:0]   cost_q, cost_d, best_q, best_d, thresh_q, thresh_d;
    logic                 busy_q, busy_d, done_q, done_d, match_q, match_d;
    logic                 terr_q, terr_d, to_flag_q, to_flag_d;
    logic [IDX_LEN:0]     n_clamp, n_minus1;
    logic                 start_acc;

`ifdef OFLOW_IOU_SCHED_TIMEOUT_EN
    localparam int WC_W = $clog2(TIMEOUT_CYC + 1);
    logic [WC_W-1:0] wcnt_q, wcnt_d;
`endif

    // busy stays high through the done cycle, so a start coinciding with done is dropped.
    assign start_acc = start && !busy_q;
    assign n_clamp   = (num_history > MAX_N) ? MAX_N : num_history;
    assign n_minus1  = n_clamp - 1'b1;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        bidx_d    = bidx_q;
        cost_d    = cost_q;
        best_d    = best_q;
        thresh_d  = thresh_q;
        busy_d    = done_q ? 1'b0 : busy_q;
        done_d    = 1'b0;
        match_d   = match_q;
        terr_d    = terr_q;
        to_flag_d = to_flag_q;
`ifdef OFLOW_IOU_SCHED_TIMEOUT_EN
        wcnt_d    = wcnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_acc) begin
                    busy_d    = 1'b1;
                    thresh_d  = cfg_thresh;
                    best_d    = '1;
                    bidx_d    = '0;
                    idx_d     = '0;
                    match_d   = 1'b0;
                    terr_d    = 1'b0;
                    to_flag_d = 1'b0;
                    last_d    = n_minus1[IDX_LEN-1:0];
                    state_d   = (n_clamp == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH:  state_d = S_LAUNCH;
            S_LAUNCH: begin
`ifdef OFLOW_IOU_SCHED_TIMEOUT_EN
                wcnt_d  = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eng_valid_iou) begin
                    cost_d  = eng_iou;
                    state_d = S_UPDATE;
                end
`ifdef OFLOW_IOU_SCHED_TIMEOUT_EN
                // Leaving at count T-2 puts the registered done pulse T cycles after WAIT entry.
                else if (wcnt_q == WC_W'(TIMEOUT_CYC - 2)) begin
                    to_flag_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
`endif
            end
            S_UPDATE: begin
                if (cost_q < best_q) begin
                    best_d = cost_q;
                    bidx_d = idx_q;
                end
                if (idx_q == last_q) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                match_d = (best_q < thresh_q) && !to_flag_q;
                terr_d  = to_flag_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            last_q    <= '0;
            bidx_q    <= '0;
            cost_q    <= '0;
            best_q    <= '1;
            thresh_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            match_q   <= 1'b0;
            terr_q    <= 1'b0;
            to_flag_q <= 1'b0;
`ifdef OFLOW_IOU_SCHED_TIMEOUT_EN
            wcnt_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            bidx_q    <= bidx_d;
            cost_q    <= cost_d;
            best_q    <= best_d;
            thresh_q  <= thresh_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            match_q   <= match_d;
            terr_q    <= terr_d;
            to_flag_q <= to_flag_d;
`ifdef OFLOW_IOU_SCHED_TIMEOUT_EN
            wcnt_q    <= wcnt_d;
`endif
        end
    end

    assign hist_rd_en   = (state_q == S_FETCH);
    assign hist_rd_addr = idx_q;
    assign eng_start    = (state_q == S_LAUNCH);
    assign score_vld    = (state_q == S_UPDATE);
    assign score_idx    = idx_q;
    assign score_data   = cost_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign best_idx     = bidx_q;
    assign best_score   = best_q;
    assign match        = match_q;
    assign timeout_err  = terr_q;

endmodule

// File: tb/tb_oflow_iou_scheduler.sv
// Directed bench for oflow_iou_scheduler (default build): engine model with fixed latency,
// monitor queues for streamed scores, one task per scenario.
module tb_oflow_iou_scheduler;

    logic        clk = 1'b0;
    logic        reset_N;
    logic        start;
    logic [4:0]  num_history;
    logic [21:0] cfg_thresh;
    logic        hist_rd_en;
    logic [3:0]  hist_rd_addr;
    logic        eng_start;
    logic        eng_valid_iou;
    logic [21:0] eng_iou;
    logic        score_vld;
    logic [3:0]  score_idx;
    logic [21:0] score_data;
    logic        busy, done, match, timeout_err;
    logic [3:0]  best_idx;
    logic [21:0] best_score;

    int passed = 0;
    int total  = 0;

    logic [21:0] eng_costs[$];
    logic [21:0] exp_q[$];
    logic [21:0] got_dat_q[$];
    logic [3:0]  got_idx_q[$];
    int          rd_cnt, es_cnt, done_cnt;
    logic [3:0]  last_addr;

    oflow_iou_scheduler dut (
        .clk(clk), .reset_N(reset_N), .start(start), .num_history(num_history),
        .cfg_thresh(cfg_thresh), .hist_rd_en(hist_rd_en), .hist_rd_addr(hist_rd_addr),
        .eng_start(eng_start), .eng_valid_iou(eng_valid_iou), .eng_iou(eng_iou),
        .score_vld(score_vld), .score_idx(score_idx), .score_data(score_data),
        .busy(busy), .done(done), .best_idx(best_idx), .best_score(best_score),
        .match(match), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Engine: result appears 3 cycles after the eng_start cycle.
    initial begin
        eng_valid_iou = 1'b0;
        eng_iou       = '0;
        forever begin
            @(negedge clk);
            if (eng_start === 1'b1) begin
                repeat (3) @(negedge clk);
                eng_valid_iou = 1'b1;
                if (eng_costs.size() > 0) eng_iou = eng_costs.pop_front();
                else eng_iou = '0;
                @(negedge clk);
                eng_valid_iou = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (hist_rd_en === 1'b1) begin
            rd_cnt++;
            last_addr = hist_rd_addr;
        end
        if (eng_start === 1'b1) es_cnt++;
        if (done === 1'b1) done_cnt++;
        if (score_vld === 1'b1) begin
            got_idx_q.push_back(score_idx);
            got_dat_q.push_back(score_data);
        end
    end

    task automatic clear_obs();
        rd_cnt = 0; es_cnt = 0; done_cnt = 0; last_addr = '0;
        got_idx_q.delete(); got_dat_q.delete(); exp_q.delete(); eng_costs.delete();
    endtask

    // Called at a negedge; start is high for the current cycle. Returns cycles until done.
    task automatic run(input logic [4:0] n, input logic [21:0] th, input int extra, output int cyc);
        num_history = n;
        cfg_thresh  = th;
        start       = 1'b1;
        cyc         = 0;
        do begin
            @(negedge clk);
            cyc++;
            start = (cyc == extra);
            if (cyc == extra) num_history = 5'd3;
        end while (done !== 1'b1 && cyc < 400);
        start = 1'b0;
    endtask

    task automatic check_scores(input string tag);
        total++;
        if (got_dat_q.size() !== exp_q.size()) begin
            $display("FAIL %s score_count got %0d exp %0d", tag, got_dat_q.size(), exp_q.size());
        end else begin
            passed++;
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (got_dat_q[i] !== exp_q[i] || got_idx_q[i] !== 4'(i))
                    $display("FAIL %s score[%0d] got idx %0d data %h exp idx %0d data %h",
                             tag, i, got_idx_q[i], got_dat_q[i], i, exp_q[i]);
                else passed++;
            end
        end
    endtask

    task automatic test_reset();
        reset_N = 1'b0; start = 1'b0; num_history = '0; cfg_thresh = '0;
        clear_obs();
        repeat (3) @(negedge clk);
        total++;
        if ({hist_rd_en, eng_start, score_vld, busy, done, match, timeout_err, best_idx,
             best_score, hist_rd_addr, score_idx, score_data} !== {7'b0, 4'd0, 22'h3FFFFF, 4'd0, 4'd0, 22'd0})
            $display("FAIL reset_values got best %h busy %b done %b", best_score, busy, done);
        else passed++;
        reset_N = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int cyc;
        clear_obs();
        eng_costs.push_back(22'h100000);
        exp_q.push_back(22'h100000);
        run(5'd1, 22'h200000, -1, cyc);
        total++;
        if (cyc !== 8) $display("FAIL single_latency got %0d exp 8", cyc); else passed++;
        total++;
        if ({best_idx, best_score, match, busy, timeout_err} !== {4'd0, 22'h100000, 1'b1, 1'b1, 1'b0})
            $display("FAIL single_result got idx %0d score %h match %b busy %b", best_idx, best_score, match, busy);
        else passed++;
        @(negedge clk); #1;
        total++;
        if (busy !== 1'b0) $display("FAIL single_busy_clear got %b exp 0", busy); else passed++;
        check_scores("single");
    endtask

    task automatic test_min_search();
        int cyc;
        clear_obs();
        eng_costs = '{22'h3FFFFF, 22'h0A0000, 22'h050000, 22'h050000};
        exp_q     = '{22'h3FFFFF, 22'h0A0000, 22'h050000, 22'h050000};
        run(5'd4, 22'h050000, -1, cyc);
        total++;
        if (cyc !== 26) $display("FAIL min_latency got %0d exp 26", cyc); else passed++;
        total++;
        if ({best_idx, best_score, match} !== {4'd2, 22'h050000, 1'b0})
            $display("FAIL min_result got idx %0d score %h match %b exp 2 050000 0", best_idx, best_score, match);
        else passed++;
        @(negedge clk); #1;
        check_scores("min");
    endtask

    task automatic test_empty();
        int cyc;
        clear_obs();
        run(5'd0, 22'h3FFFFF, -1, cyc);
        total++;
        if (cyc !== 2) $display("FAIL empty_latency got %0d exp 2", cyc); else passed++;
        total++;
        if ({best_idx, best_score, match} !== {4'd0, 22'h3FFFFF, 1'b0})
            $display("FAIL empty_result got idx %0d score %h match %b", best_idx, best_score, match);
        else passed++;
        @(negedge clk); #1;
        total++;
        if (rd_cnt !== 0 || es_cnt !== 0) $display("FAIL empty_no_access got rd %0d es %0d exp 0 0", rd_cnt, es_cnt);
        else passed++;
    endtask

    task automatic test_clamp();
        int cyc;
        clear_obs();
        for (int i = 0; i < 16; i++) begin
            eng_costs.push_back(22'(22'h200 - i * 16));
            exp_q.push_back(22'(22'h200 - i * 16));
        end
        run(5'd20, 22'h000110, 10, cyc);
        total++;
        if (cyc !== 98) $display("FAIL clamp_latency got %0d exp 98", cyc); else passed++;
        total++;
        if ({best_idx, best_score, match} !== {4'd15, 22'h000110, 1'b0})
            $display("FAIL clamp_result got idx %0d score %h match %b exp 15 000110 0", best_idx, best_score, match);
        else passed++;
        @(negedge clk); #1;
        total++;
        if (es_cnt !== 16 || rd_cnt !== 16 || last_addr !== 4'd15)
            $display("FAIL clamp_counts got es %0d rd %0d last %0d exp 16 16 15", es_cnt, rd_cnt, last_addr);
        else passed++;
        check_scores("clamp");
    endtask

    task automatic test_back_to_back();
        int cyc, rd0;
        clear_obs();
        eng_costs.push_back(22'h000123);
        run(5'd1, 22'h3FFFFF, -1, cyc);
        start = 1'b1; num_history = 5'd2;
        @(negedge clk);
        start = 1'b0;
        rd0 = rd_cnt;
        repeat (5) @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || rd_cnt !== rd0 || done_cnt !== 1)
            $display("FAIL b2b_ignored got busy %b rd %0d done %0d exp 0 %0d 1", busy, rd_cnt, done_cnt, rd0);
        else passed++;
    endtask

    task automatic test_reset_mid_run();
        int cyc, guard;
        clear_obs();
        eng_costs = '{22'h000300, 22'h000200, 22'h000100, 22'h000050};
        num_history = 5'd4; cfg_thresh = 22'h3FFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (es_cnt < 3 && guard < 200) begin
            @(negedge clk); #1; guard++;
        end
        total++;
        if (es_cnt !== 3) $display("FAIL rst_reach_idx2 got es %0d exp 3", es_cnt); else passed++;
        @(negedge clk);
        reset_N = 1'b0;
        @(negedge clk);
        total++;
        if ({hist_rd_en, eng_start, score_vld, busy, done, match, best_idx, best_score}
            !== {6'b0, 4'd0, 22'h3FFFFF})
            $display("FAIL rst_mid_values got busy %b best %h idx %0d", busy, best_score, best_idx);
        else passed++;
        reset_N = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        total++;
        if (done_cnt !== 0 || got_dat_q.size() !== 2)
            $display("FAIL rst_no_done got done %0d scores %0d exp 0 2", done_cnt, got_dat_q.size());
        else passed++;
        clear_obs();
        eng_costs = '{22'h000040, 22'h000020};
        exp_q     = '{22'h000040, 22'h000020};
        @(negedge clk);
        run(5'd2, 22'h000030, -1, cyc);
        total++;
        if (cyc !== 14 || best_idx !== 4'd1 || best_score !== 22'h000020 || match !== 1'b1)
            $display("FAIL rst_rerun got cyc %0d idx %0d score %h match %b exp 14 1 000020 1",
                     cyc, best_idx, best_score, match);
        else passed++;
        @(negedge clk); #1;
        check_scores("rerun");
    endtask

    initial begin
        test_reset();
        test_single();
        test_min_search();
        test_empty();
        test_clamp();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
